// File: rtl/adder_pkg.sv
// Shared types and width helpers for the accumulating adder pipeline.
package adder_pkg;

    // Upper bound on the stage-1 sum width carried in the S1 payload.
    localparam int unsigned SUM_MAX_W = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Stage-1 sum width: enough for N*(2^W-1)+1.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return w + clog2(n);
    endfunction

    // S1 payload: the operand sum plus the beat's accumulator controls.
    typedef struct packed {
        logic                 acc_en;
        logic                 acc_clr;
        logic [SUM_MAX_W-1:0] sum;
    } s1_beat_t;

endpackage

// File: rtl/adder_tree.sv
// Combinational sum of N unsigned W-bit operands plus a carry-in.
//   ops   : operand k at [k*W +: W]
//   cin   : carry-in
//   sum_c : unsigned sum, sum_width(W,N) bits
module adder_tree
    import adder_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
) (
    input  logic [N*W-1:0]              ops,
    input  logic                        cin,
    output logic [sum_width(W,N)-1:0]   sum_c
);

    localparam int unsigned TW = sum_width(W, N);

    // Linear chain; synthesis rebalances into a tree.
    always_comb begin
        sum_c = TW'(cin);
        for (int unsigned k = 0; k < N; k++) begin
            sum_c = sum_c + TW'(ops[k*W +: W]);
        end
    end

endmodule

// File: rtl/adder_acc_pipe.sv
// Two-stage N-operand adder with optional wrap/saturating accumulator and
// valid/ready handshakes on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from out_ready)
//   ins                 : operands at [k*W +: W], carry-in at [N*W]
//   acc_en, acc_clr     : per-beat accumulate enable / start-from-zero
//   out_valid/out_ready : output handshake
//   sm, sm_zero, sm_ovf : registered result, zero flag, accumulator overflow
module adder_acc_pipe
    import adder_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned N   = 4,
    parameter int unsigned AW  = 16,
    parameter int unsigned SAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W:0]    ins,
    input  logic            acc_en,
    input  logic            acc_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   sm,
    output logic            sm_zero,
    output logic            sm_ovf
);

    localparam int unsigned TW = sum_width(W, N);

    // Elaboration-time parameter sanity.
    if (AW < TW) begin : g_bad_aw
        $error("adder_acc_pipe: AW must be >= W + clog2(N)");
    end
    if (TW > SUM_MAX_W) begin : g_bad_tw
        $error("adder_acc_pipe: operand sum too wide for S1 payload");
    end
    if (N < 2 || N > 16 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("adder_acc_pipe: N must be a power of 2 in 2..16");
    end

    logic [TW-1:0]  tree_sum_c;
    s1_beat_t       s1_d_c;
    s1_beat_t       s1_q;
    logic           s1_valid;
    logic [AW-1:0]  acc_q;

    logic           in_fire_c;
    logic           s2_load_c;
    logic [AW-1:0]  base_c;
    logic [AW:0]    t_c;
    logic [AW-1:0]  res_c;
    logic           ovf_c;

    adder_tree #(
        .W (W),
        .N (N)
    ) u_tree (
        .ops   (ins[N*W-1:0]),
        .cin   (ins[N*W]),
        .sum_c (tree_sum_c)
    );

    // Handshake: S2 takes S1 when empty or draining; S1 refills in the same cycle.
    always_comb begin
        s2_load_c = s1_valid && (!out_valid || out_ready);
        in_ready  = !s1_valid || s2_load_c;
        in_fire_c = in_valid && in_ready;
    end

    always_comb begin
        s1_d_c         = '0;
        s1_d_c.acc_en  = acc_en;
        s1_d_c.acc_clr = acc_clr;
        s1_d_c.sum     = SUM_MAX_W'(tree_sum_c);
    end

    // Result for the beat in S1; the overflow test is the carry out of AW bits.
    always_comb begin
        base_c = s1_q.acc_clr ? '0 : acc_q;
        t_c    = {1'b0, base_c} + (AW+1)'(s1_q.sum);
        res_c  = AW'(s1_q.sum);
        ovf_c  = 1'b0;
        if (s1_q.acc_en) begin
            ovf_c = t_c[AW];
            res_c = (ovf_c && (SAT != 0)) ? '1 : t_c[AW-1:0];
        end
    end

    // Stage S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire_c) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d_c;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage S2 output register and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sm        <= '0;
            sm_zero   <= 1'b0;
            sm_ovf    <= 1'b0;
            acc_q     <= '0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            sm        <= res_c;
            sm_zero   <= (res_c == '0);
            sm_ovf    <= ovf_c;
            if (s1_q.acc_en) begin
                acc_q <= res_c;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/adder_acc_pipe.md
Name: adder_acc_pipe

Overview:
Parametrised successor to the single-cycle two-operand adder.
- Sums N unsigned W-bit operands plus a carry-in.
- Optionally accumulates the results into a running AW-bit accumulator, with wrap or saturate on overflow.
- Two-stage pipeline with valid/ready handshakes on both sides; sustains one beat per cycle.
- Sits between producer and consumer datapath blocks as a drop-in arithmetic stage.

Parameters:
W, 8, operand width in bits (≥1)
N, 4, operand count; power of 2, range 2..16
AW, 16, accumulator/result width; must satisfy AW ≥ TW
SAT, 0, 0 = wrap on accumulator overflow, 1 = clamp to all-ones

Derived: TW = W + clog2(N), the stage-1 sum width. Maximum sum is N*(2^W-1)+1, which fits in TW bits.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
ins  input  N*W+1  operand k at [k*W +: W]; carry-in at bit [N*W]
acc_en  input  1  beat-qualified: add this sum into the accumulator
acc_clr  input  1  beat-qualified: start the accumulator from 0 for this beat
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
sm  output  AW  result
sm_zero  output  1  sm == 0
sm_ovf  output  1  accumulator overflow occurred on this beat

Behaviour:
- Reset (asynchronous, active-low): in_ready=1 once reset is released; out_valid=0, sm=0, sm_zero=0, sm_ovf=0.
  - The accumulator and all stage valids clear to 0.
  - Beats in flight when reset asserts are dropped; no partial output is produced.
- Handshake:
  - A transfer occurs when valid && ready on a rising clk edge.
  - ins, acc_en and acc_clr are sampled only at an input transfer.
  - A producer must hold in_valid and its data until accepted.
- Stage S1:
  - Captures s1_sum = Σ operands + cin (TW bits, unsigned), together with acc_en and acc_clr.
  - s1_valid is set on input transfer and cleared when S1 advances without a new input.
- Stage S2 (output register):
  - Loads from S1 when S2 is empty or out_ready=1.
  - in_ready = !s1_valid || (S2 loading). This is a combinational path from out_ready; it is allowed.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Under backpressure (out_ready=0 while out_valid=1):
  - sm, sm_zero and sm_ovf hold stable.
  - S1 holds one beat; in_ready drops once S1 is full.
  - No beat is lost or duplicated; order is preserved.
- Result computation at the S1→S2 move:
  - base = acc_clr ? 0 : acc.
  - If acc_en=0: sm = zero-extended s1_sum, sm_ovf=0. The accumulator is unchanged, even if acc_clr=1.
  - If acc_en=1: t = base + s1_sum, computed at AW+1 bits.
    - If t < 2^AW: result = t[AW-1:0], sm_ovf=0.
    - Otherwise sm_ovf=1, and result = SAT ? all-ones : t[AW-1:0].
    - The accumulator is updated to the result, and sm = result.
- sm_zero is registered alongside sm: 1 exactly when the registered sm equals 0.
- Outputs change only on an S2 load; they are never combinational from ins.

Decomposition:
- Shared package adder_pkg:
  - clog2 function.
  - Localparam helpers for TW.
  - A packed struct for the S1 stage (sum, acc_en, acc_clr).
- One natural sub-module: adder_tree, a purely combinational N-operand plus carry-in sum of width TW, instantiated in S1.
- Handshake and accumulator logic stay in the top module.

Test Plan:
All scenarios use W=8, N=4, AW=12 unless stated.
1. Basic sum: ops 10,20,30,40, cin=1, acc_en=0, out_ready=1 -> out_valid 2 cycles later with sm=101, sm_zero=0, sm_ovf=0.
2. Zero flag: all operands 0, cin=0 -> sm=0, sm_zero=1.
3. Accumulate with wrap (SAT=0): ops all 255, cin=1 (sum 1021).
   - First beat acc_clr=1, acc_en=1; then 4 beats with acc_en=1 -> sm = 1021, 2042, 3063, 4084, then 1009 with sm_ovf=1.
   - Rerun with SAT=1 -> 5th beat gives sm=4095, sm_ovf=1.
4. Backpressure: stream beats with sums 1..6 while out_ready=0 for 5 cycles -> in_ready drops after 2 accepted beats and sm holds 1. After release, outputs are 1..6 in order, with no gaps or duplicates.
5. Reset mid-operation: accumulator at 500 with a beat in each stage, pulse rst_n low -> all outputs 0 and out_valid=0. The first post-reset beat with sum 7, acc_en=1, acc_clr=0 -> sm=7.
6. Non-accumulate interleave: acc=300, then a beat with acc_en=0, acc_clr=1, sum 5 -> sm=5. Next beat acc_en=1, sum 1 -> sm=301, showing the accumulator was untouched.
